hvac_actuator_sequencer: RTL and testbench

HVAC_ACTUATOR_SEQUENCER -- requirements
Module: hvac_actuator_sequencer

---
 rtl/hvac_pkg.sv | 31 +++
 rtl/hvac_phase_timer.sv | 35 +++
 rtl/hvac_actuator_sequencer.sv | 117 +++++++++++
 tb/tb_hvac_actuator_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// Shared types and constants for the HVAC actuator sequencer.
// Holds the state and mode enums, the phase counter width and the default phase lengths.
package hvac_pkg;

  localparam int unsigned CNT_W = 8;

  localparam int unsigned DEF_FAN_PRE_TICKS  = 2;
  localparam int unsigned DEF_MIN_ON_TICKS   = 10;
  localparam int unsigned DEF_FAN_POST_TICKS = 5;
  localparam int unsigned DEF_MIN_OFF_TICKS  = 30;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFanPre  = 3'd1,
    StHeat    = 3'd2,
    StCool    = 3'd3,
    StFanPost = 3'd4,
    StLockout = 3'd5
  } hvac_state_e;

  typedef enum logic {
    ModeHeat = 1'b0,
    ModeCool = 1'b1
  } hvac_mode_e;

  // Phase lengths wider than the counter are truncated to its width.
  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/hvac_phase_timer.sv
// Loadable down-counter for phase timing. It decrements only on tick and saturates at zero.
// A load takes priority over a tick that arrives in the same cycle.
module hvac_phase_timer
  import hvac_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hvac_actuator_sequencer.sv
// Sequences the heater, compressor and blower with a fan pre-run, a minimum run time,
// a fan overrun and a lockout. The outputs are decoded from registered state only.
module hvac_actuator_sequencer
  import hvac_pkg::*;
#(
  parameter int unsigned FAN_PRE_TICKS  = DEF_FAN_PRE_TICKS,
  parameter int unsigned MIN_ON_TICKS   = DEF_MIN_ON_TICKS,
  parameter int unsigned FAN_POST_TICKS = DEF_FAN_POST_TICKS,
  parameter int unsigned MIN_OFF_TICKS  = DEF_MIN_OFF_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       heat_req,
  input  logic       cool_req,
  input  logic       fan_req,
  output logic       heater_on,
  output logic       aircon_on,
  output logic       fan_on,
  output logic [2:0] state_o,
  output logic       conflict
);

  hvac_state_e      state_q, state_d;
  hvac_mode_e       mode_q, mode_d;
  logic             fan_req_q, conflict_q;
  logic             heat_v, cool_v, mode_dem;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;

  // A simultaneous heat and cool request counts as no demand at all.
  assign heat_v   = heat_req & ~cool_req;
  assign cool_v   = cool_req & ~heat_req;
  assign mode_dem = (mode_q == ModeCool) ? cool_v : heat_v;

  hvac_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tick),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (heat_v || cool_v) begin
          state_d      = StFanPre;
          mode_d       = heat_v ? ModeHeat : ModeCool;
          tmr_load     = 1'b1;
          tmr_load_val = to_cnt(FAN_PRE_TICKS);
        end
      end
      StFanPre: begin
        if (!mode_dem) begin
          state_d = StIdle;
        end else if (tmr_zero) begin
          state_d      = (mode_q == ModeCool) ? StCool : StHeat;
          tmr_load     = 1'b1;
          tmr_load_val = to_cnt(MIN_ON_TICKS);
        end
      end
      // Losing demand early does not end the run; the minimum run time always completes.
      StHeat, StCool: begin
        if (tmr_zero && !mode_dem) begin
          state_d      = StFanPost;
          tmr_load     = 1'b1;
          tmr_load_val = to_cnt(FAN_POST_TICKS);
        end
      end
      StFanPost: begin
        if (tmr_zero) begin
          state_d      = StLockout;
          tmr_load     = 1'b1;
          tmr_load_val = to_cnt(MIN_OFF_TICKS);
        end
      end
      StLockout: begin
        if (tmr_zero) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      mode_q     <= ModeHeat;
      fan_req_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fan_req_q  <= fan_req;
      conflict_q <= heat_req & cool_req;
    end
  end

  always_comb begin
    heater_on = (state_q == StHeat);
    aircon_on = (state_q == StCool);
    fan_on    = (state_q == StFanPre) || (state_q == StHeat) || (state_q == StCool) ||
                (state_q == StFanPost) || ((state_q == StIdle) && fan_req_q);
    state_o   = state_q;
    conflict  = conflict_q;
  end

endmodule

// File: tb/tb_hvac_actuator_sequencer.sv
// Randomized and directed bench for hvac_actuator_sequencer.
// A phase/ticks-left reference model gives the expected outputs for every cycle.
module tb_hvac_actuator_sequencer;

  localparam int P_PRE  = 2;
  localparam int P_ON   = 3;
  localparam int P_POST = 2;
  localparam int P_OFF  = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HEAT = 3'd2;
  localparam logic [2:0] S_COOL = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_LOCK = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       heat_req = 1'b0;
  logic       cool_req = 1'b0;
  logic       fan_req = 1'b0;
  logic       heater_on, aircon_on, fan_on, conflict;
  logic [2:0] state_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: current phase, ticks left in it, latched mode and the registered inputs.
  logic [2:0] m_ph;
  int         m_left;
  bit         m_cool;
  bit         m_fanq;
  bit         m_conf;

  logic [2:0] obs_pre;
  logic       obs_tick;

  hvac_actuator_sequencer #(
    .FAN_PRE_TICKS  (P_PRE),
    .MIN_ON_TICKS   (P_ON),
    .FAN_POST_TICKS (P_POST),
    .MIN_OFF_TICKS  (P_OFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .heat_req  (heat_req),
    .cool_req  (cool_req),
    .fan_req   (fan_req),
    .heater_on (heater_on),
    .aircon_on (aircon_on),
    .fan_on    (fan_on),
    .state_o   (state_o),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_vec();
    logic h, a, f;
    h = (m_ph == S_HEAT);
    a = (m_ph == S_COOL);
    f = (m_ph != S_IDLE && m_ph != S_LOCK) || (m_ph == S_IDLE && m_fanq);
    return {h, a, f, m_ph, m_conf};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {heater_on, aircon_on, fan_on, state_o, conflict};
  endfunction

  task automatic model_reset();
    m_ph = S_IDLE; m_left = 0; m_cool = 1'b0; m_fanq = 1'b0; m_conf = 1'b0;
  endtask

  task automatic model_next(input logic h, input logic c, input logic f, input logic t);
    logic [2:0] ph;
    int         left;
    bit         hv, cv, dem;
    hv   = h && !c;
    cv   = c && !h;
    dem  = m_cool ? cv : hv;
    ph   = m_ph;
    left = (t && m_left > 0) ? m_left - 1 : m_left;
    case (m_ph)
      S_IDLE: if (hv || cv) begin ph = S_PRE; m_cool = cv; left = P_PRE; end
      S_PRE: begin
        if (!dem) ph = S_IDLE;
        else if (m_left == 0) begin ph = m_cool ? S_COOL : S_HEAT; left = P_ON; end
      end
      S_HEAT, S_COOL: if (m_left == 0 && !dem) begin ph = S_POST; left = P_POST; end
      S_POST: if (m_left == 0) begin ph = S_LOCK; left = P_OFF; end
      S_LOCK: if (m_left == 0) ph = S_IDLE;
      default: ph = S_IDLE;
    endcase
    m_ph   = ph;
    m_left = left;
    m_fanq = f;
    m_conf = h && c;
  endtask

  // One clock: drive inputs, advance the model, then settle 1 time unit past the edge.
  task automatic step(input logic h, input logic c, input logic f);
    heat_req = h; cool_req = c; fan_req = f;
    tick     = (cyc % 4 == 3);
    obs_pre  = state_o;
    obs_tick = tick;
    model_next(h, c, f, tick);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    heat_req = 1'b0; cool_req = 1'b0; fan_req = 1'b0; tick = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (obs_vec() !== 7'b0) begin
      bad++; $display("FAIL reset_async: got %b want %b", obs_vec(), 7'b0);
    end
    do_reset();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_state: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_heat_hold();
    int ticks;
    int guard;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (fan_on !== 1'b1 || heater_on !== 1'b0 || state_o !== S_PRE) begin
      bad++; $display("FAIL heat_fan_first: got fan=%b heat=%b st=%0d want 1 0 %0d",
                      fan_on, heater_on, state_o, S_PRE);
    end
    ticks = 0; guard = 0;
    while (heater_on !== 1'b1 && guard < 100) begin
      step(1'b1, 1'b0, 1'b0);
      if (obs_tick && obs_pre == S_PRE) ticks++;
      guard++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL heat_hold_model: got %b want %b", obs_vec(), exp_vec());
      end
    end
    total++;
    if (guard >= 100 || ticks != P_PRE) begin
      bad++; $display("FAIL heat_pre_ticks: got %0d (guard %0d) want %0d", ticks, guard, P_PRE);
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 1'b0);
      total++;
      if (heater_on !== 1'b1 || aircon_on !== 1'b0 || fan_on !== 1'b1) begin
        bad++; $display("FAIL heat_held_on: got h=%b a=%b f=%b want 1 0 1",
                        heater_on, aircon_on, fan_on);
      end
    end
  endtask

  task automatic test_heat_pulse();
    int ticks;
    int guard;
    do_reset();
    guard = 0;
    while (heater_on !== 1'b1 && guard < 100) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    ticks = 0; guard = 0;
    while (heater_on === 1'b1 && guard < 200) begin
      step(1'b0, 1'b0, 1'b0);
      if (obs_tick && obs_pre == S_HEAT) ticks++;
      guard++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL pulse_model: got %b want %b", obs_vec(), exp_vec());
      end
    end
    total++;
    if (ticks != P_ON || state_o !== S_POST) begin
      bad++; $display("FAIL pulse_on_ticks: got %0d st=%0d want %0d st=%0d",
                      ticks, state_o, P_ON, S_POST);
    end
    ticks = 0; guard = 0;
    while (fan_on === 1'b1 && guard < 200) begin
      step(1'b0, 1'b0, 1'b0);
      if (obs_tick && obs_pre == S_POST) ticks++;
      guard++;
    end
    total++;
    if (ticks != P_POST || state_o !== S_LOCK) begin
      bad++; $display("FAIL pulse_post_ticks: got %0d st=%0d want %0d st=%0d",
                      ticks, state_o, P_POST, S_LOCK);
    end
    ticks = 0; guard = 0;
    while (state_o === S_LOCK && guard < 200) begin
      step(1'b1, 1'b0, 1'b0);
      if (obs_tick && obs_pre == S_LOCK) ticks++;
      guard++;
      total++;
      if ((heater_on | aircon_on | fan_on) !== 1'b0 && state_o === S_LOCK) begin
        bad++; $display("FAIL lockout_quiet: got h=%b a=%b f=%b want 0 0 0",
                        heater_on, aircon_on, fan_on);
      end
    end
    total++;
    if (ticks != P_OFF || state_o !== S_IDLE) begin
      bad++; $display("FAIL lockout_ticks: got %0d st=%0d want %0d st=%0d",
                      ticks, state_o, P_OFF, S_IDLE);
    end
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (state_o !== S_PRE) begin
      bad++; $display("FAIL after_lockout: got st=%0d want %0d", state_o, S_PRE);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (conflict !== 1'b1 || state_o !== S_IDLE || {heater_on, aircon_on, fan_on} !== 3'b000) begin
      bad++; $display("FAIL conflict_set: got c=%b st=%0d act=%b want 1 0 000",
                      conflict, state_o, {heater_on, aircon_on, fan_on});
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (conflict !== 1'b0 || state_o !== S_IDLE) begin
      bad++; $display("FAIL conflict_clear: got c=%b st=%0d want 0 0", conflict, state_o);
    end
  endtask

  task automatic test_cool_to_heat();
    int  guard;
    bit  saw_post, saw_lock, both;
    do_reset();
    guard = 0;
    while (aircon_on !== 1'b1 && guard < 100) begin
      step(1'b0, 1'b1, 1'b0);
      guard++;
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    total++;
    if (aircon_on !== 1'b1 || heater_on !== 1'b0) begin
      bad++; $display("FAIL cool_running: got a=%b h=%b want 1 0", aircon_on, heater_on);
    end
    saw_post = 0; saw_lock = 0; both = 0; guard = 0;
    while (heater_on !== 1'b1 && guard < 300) begin
      step(1'b1, 1'b0, 1'b0);
      if (state_o === S_POST) saw_post = 1;
      if (state_o === S_LOCK) saw_lock = 1;
      if (heater_on === 1'b1 && aircon_on === 1'b1) both = 1;
      guard++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL switch_model: got %b want %b", obs_vec(), exp_vec());
      end
    end
    total++;
    if (guard >= 300 || !saw_post || !saw_lock || both) begin
      bad++; $display("FAIL mode_switch: got guard=%0d post=%0b lock=%0b both=%0b want <300 1 1 0",
                      guard, saw_post, saw_lock, both);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    guard = 0;
    while (aircon_on !== 1'b1 && guard < 100) begin
      step(1'b0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    total++;
    if (aircon_on !== 1'b0 || fan_on !== 1'b0 || state_o !== S_IDLE) begin
      bad++; $display("FAIL async_reset: got a=%b f=%b st=%0d want 0 0 0",
                      aircon_on, fan_on, state_o);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (state_o !== S_PRE || fan_on !== 1'b1) begin
      bad++; $display("FAIL post_reset_entry: got st=%0d f=%b want %0d 1", state_o, fan_on, S_PRE);
    end
  endtask

  task automatic test_fan_only();
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    total++;
    if ({heater_on, aircon_on, fan_on} !== 3'b001) begin
      bad++; $display("FAIL fan_only_on: got %b want 001", {heater_on, aircon_on, fan_on});
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (fan_on !== 1'b0) begin
      bad++; $display("FAIL fan_only_off: got %b want 0", fan_on);
    end
  endtask

  task automatic test_random();
    logic h, c, f;
    int   hold;
    do_reset();
    h = 0; c = 0; f = 0; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        h    = ($urandom_range(0, 2) == 0);
        c    = ($urandom_range(0, 2) == 0);
        f    = $urandom_range(0, 1) == 1;
        hold = $urandom_range(1, 25);
      end
      hold--;
      step(h, c, f);
      total++;
      if (obs_vec() !== exp_vec() || (heater_on === 1'b1 && aircon_on === 1'b1)) begin
        bad++; $display("FAIL random_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_heat_hold();
    test_heat_pulse();
    test_conflict();
    test_cool_to_heat();
    test_async_reset();
    test_fan_only();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
